// File: rtl/uart_rx_fifo_if.sv
// Bundle for uart_rx_fifo: serial line, option register and the Nios-side FIFO read port.
// The rts_n signal exists only when UART_RX_RTS_EN is defined.
interface uart_rx_fifo_if #(
  parameter int FIFO_AW = 4
) ();
  logic             serial_in;
  logic [7:0]       usr_options;
  logic             data_read_nios;
  logic             new_data;
  logic [7:0]       data_in_nios;
  logic             parity_err;
  logic             frame_err;
  logic             overrun;
  logic [FIFO_AW:0] fifo_count;
  logic             rx_busy;
`ifdef UART_RX_RTS_EN
  logic             rts_n;

  modport master (
    output serial_in, usr_options, data_read_nios,
    input  new_data, data_in_nios, parity_err, frame_err, overrun, fifo_count, rx_busy, rts_n
  );
  modport slave (
    input  serial_in, usr_options, data_read_nios,
    output new_data, data_in_nios, parity_err, frame_err, overrun, fifo_count, rx_busy, rts_n
  );
`else
  modport master (
    output serial_in, usr_options, data_read_nios,
    input  new_data, data_in_nios, parity_err, frame_err, overrun, fifo_count, rx_busy
  );
  modport slave (
    input  serial_in, usr_options, data_read_nios,
    output new_data, data_in_nios, parity_err, frame_err, overrun, fifo_count, rx_busy
  );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with its own oversampling baud generator, 5-8 bit framing and a read FIFO.
// Define UART_RX_RTS_EN to add the rts_n flow-control output driven from usr_options B5.
//
// state    | meaning
// IDLE     | waiting for a 1->0 edge on the synchronised line
// START    | confirming the start bit at mid-bit
// DATA     | sampling N data bits, LSB first
// PARITY   | sampling and checking the parity bit
// STOP1    | sampling the first stop bit
// STOP2    | sampling the second stop bit
// PUSH     | one cycle: write {ferr, perr, data} into the FIFO
// BRK_WAIT | line held low after a bad stop bit; wait for it to return high
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input logic           sys_clk,
  input logic           reset,
  uart_rx_fifo_if.slave bus
);
  localparam int DIV_0 = (CLK_FREQ + 9600 * OVERSAMPLE / 2) / (9600 * OVERSAMPLE);
  localparam int DIV_1 = (CLK_FREQ + 19200 * OVERSAMPLE / 2) / (19200 * OVERSAMPLE);
  localparam int DIV_2 = (CLK_FREQ + 57600 * OVERSAMPLE / 2) / (57600 * OVERSAMPLE);
  localparam int DIV_3 = (CLK_FREQ + 115200 * OVERSAMPLE / 2) / (115200 * OVERSAMPLE);
  localparam int DIV_W = $clog2(DIV_0 + 1);
  localparam int SC_W  = $clog2(OVERSAMPLE);
  localparam logic [SC_W-1:0]  SC_HALF  = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_PUSH, S_BRK_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [SC_W-1:0]    sc_q, sc_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         data_q, data_d;
  logic               perr_q, perr_d;
  logic               ferr_q, ferr_d;
  logic [7:0]         opt_q, opt_d;
  logic               sync1_q, sync2_q, rx_prev_q;
  logic               rx_s, fall, tick, bit_tick;
  logic [2:0]         last_bit;

  logic [9:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overrun_q, overrun_d;
  logic               push, pop, wr_en;
  logic [9:0]         head;

  function automatic logic [DIV_W-1:0] div_load(input logic [1:0] baud);
    case (baud)
      2'd0:    div_load = DIV_W'(DIV_0 - 1);
      2'd1:    div_load = DIV_W'(DIV_1 - 1);
      2'd2:    div_load = DIV_W'(DIV_2 - 1);
      default: div_load = DIV_W'(DIV_3 - 1);
    endcase
  endfunction

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= bus.serial_in;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  assign rx_s     = sync2_q;
  assign fall     = rx_prev_q & ~sync2_q;
  assign tick     = (div_q == '0);
  assign bit_tick = tick && (sc_q == SC_LAST);
  assign last_bit = 3'd7 - {1'b0, opt_q[3:2]};

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sc_q    <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      opt_q   <= '0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      opt_q   <= opt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    div_d   = div_q;
    bit_d   = bit_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    opt_d   = opt_q;

    // Baud down-counter only runs while a frame is in flight
    if (state_q != S_IDLE) begin
      if (tick) begin
        div_d = div_load(opt_q[7:6]);
        sc_d  = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
      end else begin
        div_d = div_q - 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d = S_START;
          sc_d    = '0;
          div_d   = div_load(bus.usr_options[7:6]);
          opt_d   = bus.usr_options;
          bit_d   = '0;
          data_d  = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (tick && (sc_q == SC_HALF)) begin
          sc_d    = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          data_d[bit_q] = rx_s;
          bit_d         = bit_q + 3'd1;
          if (bit_q == last_bit) state_d = opt_q[0] ? S_PARITY : S_STOP1;
        end
      end
      S_PARITY: begin
        if (bit_tick) begin
          perr_d  = ((^data_q) ^ rx_s) != opt_q[1];
          state_d = S_STOP1;
        end
      end
      S_STOP1: begin
        if (bit_tick) begin
          if (!rx_s) ferr_d = 1'b1;
          state_d = opt_q[4] ? S_STOP2 : S_PUSH;
        end
      end
      S_STOP2: begin
        if (bit_tick) begin
          if (!rx_s) ferr_d = 1'b1;
          state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        state_d = ferr_q ? S_BRK_WAIT : S_IDLE;
      end
      S_BRK_WAIT: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign push  = (state_q == S_PUSH);
  assign pop   = bus.data_read_nios && (count_q != '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign wr_en = push && ((count_q != FULL_CNT) || pop);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push && !wr_en) overrun_d = 1'b1;
    else if (pop)       overrun_d = 1'b0;
  end

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {ferr_q, perr_q, data_q};
  end

  // Head is gated while empty so stale storage never reaches the outputs
  assign head             = mem_q[rd_ptr_q];
  assign bus.new_data     = (count_q != '0);
  assign bus.data_in_nios = bus.new_data ? head[7:0] : 8'h00;
  assign bus.parity_err   = bus.new_data & head[8];
  assign bus.frame_err    = bus.new_data & head[9];
  assign bus.overrun      = overrun_q;
  assign bus.fifo_count   = count_q;
  assign bus.rx_busy      = (state_q != S_IDLE);

`ifdef UART_RX_RTS_EN
  localparam logic [FIFO_AW:0] RTS_HI = (FIFO_AW + 1)'(FIFO_DEPTH - 2);
  localparam logic [FIFO_AW:0] RTS_LO = (FIFO_AW + 1)'(FIFO_DEPTH / 2);
  logic rts_q, rts_d;

  always_comb begin
    rts_d = rts_q;
    if (!opt_q[5])              rts_d = 1'b0;
    else if (count_q >= RTS_HI) rts_d = 1'b1;
    else if (count_q <= RTS_LO) rts_d = 1'b0;
  end

  always_ff @(posedge sys_clk) begin
    if (!reset) rts_q <= 1'b0;
    else        rts_q <= rts_d;
  end

  assign bus.rts_n = rts_q;
`else
  logic unused_opt_b5;
  assign unused_opt_b5 = opt_q[5];
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are serialised from random or directed options,
// the expected FIFO entry is queued, and a monitor pops and compares the DUT head.
module tb_uart_rx_fifo;
  localparam int CLK_FREQ = 3686400;
  localparam int OS       = 16;
  localparam int DEPTH    = 16;
  localparam int AW       = 4;

  logic sys_clk = 1'b0;
  logic reset   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  uart_rx_fifo_if #(.FIFO_AW(AW)) bus ();

  uart_rx_fifo #(
    .CLK_FREQ(CLK_FREQ), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)
  ) dut (
    .sys_clk(sys_clk),
    .reset  (reset),
    .bus    (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [9:0] exp_q[$];
  bit         exp_ovr  = 1'b0;
  int         pop_req  = 0;
  int         pop_done = 0;

  function automatic int bit_cycles(input logic [1:0] sel);
    int b;
    case (sel)
      2'd0:    b = 9600;
      2'd1:    b = 19200;
      2'd2:    b = 57600;
      default: b = 115200;
    endcase
    return ((CLK_FREQ + b * OS / 2) / (b * OS)) * OS;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"},    32'(bus.fifo_count), 32'(exp_q.size()));
    check({tag, "_overrun"},  32'(bus.overrun),    32'(exp_ovr));
    check({tag, "_new_data"}, 32'(bus.new_data),   32'(exp_q.size() != 0));
  endtask

  // Serialise one frame; the expected entry is derived from the framing rules alone
  task automatic send_frame(input logic [7:0] opts, input logic [7:0] d, input bit bad_par,
                            input bit bad_s1, input bit bad_s2, input bit scramble,
                            input int hold_bits);
    int         per;
    int         n;
    logic [7:0] dm;
    logic       p, perr, ferr;
    per  = bit_cycles(opts[7:6]);
    n    = 8 - int'(opts[3:2]);
    dm   = d;
    for (int i = n; i < 8; i++) dm[i] = 1'b0;
    p    = (^dm) ^ opts[1] ^ bad_par;
    perr = opts[0] & bad_par;
    ferr = bad_s1 | (opts[4] & bad_s2);
    if (exp_q.size() < DEPTH) exp_q.push_back({ferr, perr, dm});
    else                      exp_ovr = 1'b1;
    bus.usr_options = opts;
    cycles(1);
    bus.serial_in = 1'b0;
    if (scramble) begin
      cycles(per / 2);
      bus.usr_options = 8'($urandom);
      cycles(per - per / 2);
    end else begin
      cycles(per);
    end
    for (int i = 0; i < n; i++) begin
      bus.serial_in = dm[i];
      cycles(per);
    end
    if (opts[0]) begin
      bus.serial_in = p;
      cycles(per);
    end
    bus.serial_in = ~bad_s1;
    cycles(per);
    if (opts[4]) begin
      bus.serial_in = ~bad_s2;
      cycles(per);
    end
    if (hold_bits > 0) begin
      bus.serial_in = 1'b0;
      cycles(hold_bits * per);
    end else begin
      bus.serial_in = 1'b1;
    end
  endtask

  task automatic drain(input int n);
    int start;
    if (n == 0) return;
    start   = pop_done;
    pop_req = pop_req + n;
    for (int i = 0; i < n * 4 + 20 && pop_done != pop_req; i++) cycles(1);
    check("drain_done", 32'(pop_done), 32'(pop_req));
    if (pop_done != start) exp_ovr = 1'b0;
    pop_req = pop_done;
    cycles(2);
  endtask

  // Monitor: pops the head whenever a read has been requested and compares it
  initial begin : monitor
    logic [9:0] e;
    bus.data_read_nios = 1'b0;
    forever begin
      @(negedge sys_clk);
      bus.data_read_nios = 1'b0;
      if (reset && (pop_done < pop_req) && bus.new_data) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_entry: got data 0x%0h, expected an empty FIFO", bus.data_in_nios);
        end else begin
          e = exp_q.pop_front();
          check("head_data", 32'(bus.data_in_nios), 32'(e[7:0]));
          check("head_perr", 32'(bus.parity_err),   32'(e[8]));
          check("head_ferr", 32'(bus.frame_err),    32'(e[9]));
        end
        bus.data_read_nios = 1'b1;
        pop_done++;
      end
    end
  end

  initial begin : watchdog
    #4000000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] opts;
    bit         seen;
    int         per;
    bus.serial_in   = 1'b1;
    bus.usr_options = 8'h00;
    reset           = 1'b0;
    cycles(3);
    check("rst_new_data", 32'(bus.new_data),     32'd0);
    check("rst_data",     32'(bus.data_in_nios), 32'd0);
    check("rst_perr",     32'(bus.parity_err),   32'd0);
    check("rst_ferr",     32'(bus.frame_err),    32'd0);
    check("rst_overrun",  32'(bus.overrun),      32'd0);
    check("rst_count",    32'(bus.fifo_count),   32'd0);
    check("rst_busy",     32'(bus.rx_busy),      32'd0);
`ifdef UART_RX_RTS_EN
    check("rst_rts",      32'(bus.rts_n),        32'd0);
`endif
    reset = 1'b1;
    cycles(4);

    // 8N1 at 115200
    send_frame(8'hC0, 8'hA5, 0, 0, 0, 0, 0);
    cycles(4);
    check("t1_data", 32'(bus.data_in_nios), 32'hA5);
    check_state("t1");
    drain(1);
    check_state("t1_post");

    // 9600, 5 data bits, odd parity: wrong then correct parity bit
    send_frame(8'h0F, 8'h13, 1, 0, 0, 0, 0);
    cycles(4);
    check("t2_perr", 32'(bus.parity_err), 32'd1);
    drain(1);
    send_frame(8'h0F, 8'h13, 0, 0, 0, 0, 0);
    cycles(4);
    check("t2_perr_ok", 32'(bus.parity_err), 32'd0);
    drain(1);

    // Bad second stop bit followed by a long break
    send_frame(8'hD0, 8'h5A, 0, 0, 1, 0, 20);
    check("t3_busy_in_break", 32'(bus.rx_busy), 32'd1);
    check_state("t3_break");
    bus.serial_in = 1'b1;
    for (int i = 0; i < 10 && bus.rx_busy; i++) cycles(1);
    check("t3_busy_after", 32'(bus.rx_busy), 32'd0);
    check_state("t3_after");
    drain(1);

    // Overflow: 18 words into a 16-deep FIFO
    for (int b = 0; b < 18; b++) begin
      send_frame(8'hC0, 8'(b), 0, 0, 0, 0, 0);
      cycles(4);
    end
    check_state("t4_full");
    check("t4_head", 32'(bus.data_in_nios), 32'h00);
    drain(1);
    check("t4_head_next", 32'(bus.data_in_nios), 32'h01);
    check_state("t4_pop");
    drain(exp_q.size());
    check_state("t4_empty");

    // Short glitch on an idle line
    bus.usr_options = 8'hC0;
    bus.serial_in   = 1'b0;
    cycles(2);
    bus.serial_in   = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      cycles(1);
      seen = bus.rx_busy;
    end
    check("t5_glitch_seen", 32'(seen), 32'd1);
    for (int i = 0; i < (OS / 2 + 2) * 2 + 4 && bus.rx_busy; i++) cycles(1);
    check("t5_glitch_idle", 32'(bus.rx_busy), 32'd0);
    check_state("t5_glitch");

    // Reset in the middle of a frame with one word already buffered
    send_frame(8'hC0, 8'h77, 0, 0, 0, 0, 0);
    cycles(4);
    check_state("t5_pre_reset");
    per = bit_cycles(2'd3);
    bus.serial_in = 1'b0;
    cycles(per * 3);
    reset = 1'b0;
    cycles(2);
    exp_q.delete();
    exp_ovr = 1'b0;
    check("t5_rst_busy", 32'(bus.rx_busy),      32'd0);
    check("t5_rst_data", 32'(bus.data_in_nios), 32'd0);
    check_state("t5_rst");
    bus.serial_in = 1'b1;
    reset = 1'b1;
    cycles(5);
    send_frame(8'hC0, 8'h3C, 0, 0, 0, 0, 0);
    cycles(4);
    check_state("t5_recover");
    drain(1);

`ifdef UART_RX_RTS_EN
    // Flow control with hysteresis
    for (int b = 0; b < 14; b++) begin
      send_frame(8'hE0, 8'(b + 8'h40), 0, 0, 0, 0, 0);
      cycles(4);
      if (b == 12) check("t6_rts_13", 32'(bus.rts_n), 32'd0);
    end
    check("t6_rts_14", 32'(bus.rts_n), 32'd1);
    drain(5);
    check("t6_rts_9", 32'(bus.rts_n), 32'd1);
    drain(1);
    check("t6_rts_8", 32'(bus.rts_n), 32'd0);
    drain(exp_q.size());
`endif

    // Randomised frames, options changed mid-frame, occasional bulk drains
    for (int k = 0; k < 24; k++) begin
      opts      = 8'($urandom);
      opts[7:6] = 2'($urandom_range(1, 3));
      send_frame(opts, 8'($urandom), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                 bit'($urandom_range(0, 1)), 0);
      cycles(4 + $urandom_range(0, 20));
      check_state("rnd");
      if ($urandom_range(0, 3) != 0) drain(exp_q.size());
    end
    drain(exp_q.size());
    check_state("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
